game_reg_bank: RTL and testbench

//  Parametrised Avalon-MM (8-bit) register bank between the HPS bus and the VGA game renderer.

---
 rtl/game_reg_bank.sv | 215 +++++++++++++++++++++
 tb/tb_game_reg_bank.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_reg_bank.sv
// game_reg_bank: Avalon-MM 8-bit register bank feeding the VGA game renderer.
// Geometry writes land in shadow registers and reach the renderer at a frame-boundary commit.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   chipselect, write,  Avalon-MM slave: byte-wide registers,
//   read, address,      readdata valid one cycle after a read strobe
//   writedata, readdata
//   frame_start         1-cycle vblank pulse; commits shadow->active, bumps frame counter
//   pillar_x, pillar_h  active pillar geometry, pillar i at [16i+15:16i] / [8i+7:8i]
//   score, bird_y, move active scene fields
//   start, audio_ctrl   immediate control fields
//   irq                 frame-commit interrupt (irq_flag & irq_en), level

module game_reg_bank #(
    parameter int NUM_PILLARS    = 3,
    parameter int ADDR_W         = 6,
    parameter int AUTO_COMMIT    = 0,
    parameter int PILLAR_SPACING = 250
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic                     read,
    input  logic [ADDR_W-1:0]        address,
    input  logic [7:0]               writedata,
    output logic [7:0]               readdata,
    input  logic                     frame_start,
    output logic [16*NUM_PILLARS-1:0] pillar_x,
    output logic [8*NUM_PILLARS-1:0]  pillar_h,
    output logic [15:0]              score,
    output logic [15:0]              bird_y,
    output logic [7:0]               move,
    output logic                     start,
    output logic [1:0]               audio_ctrl,
    output logic                     irq
);

    localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(8'h01);
    localparam logic [ADDR_W-1:0] A_FCNT  = ADDR_W'(8'h02);
    localparam logic [ADDR_W-1:0] A_AUDIO = ADDR_W'(8'h03);
    localparam logic [ADDR_W-1:0] A_SC_HI = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_SC_LO = ADDR_W'(8'h05);
    localparam logic [ADDR_W-1:0] A_BD_HI = ADDR_W'(8'h06);
    localparam logic [ADDR_W-1:0] A_BD_LO = ADDR_W'(8'h07);
    localparam logic [ADDR_W-1:0] A_MOVE  = ADDR_W'(8'h08);

    localparam logic [15:0] SCORE_RST = 16'h0888;
    localparam logic [15:0] BIRD_RST  = 16'd200;
    localparam logic [7:0]  MOVE_RST  = 8'd5;

    function automatic logic [15:0] f_x_rst(input int i);
        return 16'(50 + i * PILLAR_SPACING);
    endfunction

    function automatic logic [7:0] f_h_rst(input int i);
        return 8'(10 + 5 * i);
    endfunction

    function automatic logic [ADDR_W-1:0] f_pa(input int i, input int off);
        return ADDR_W'(16 + 4 * i + off);
    endfunction

    logic                 r_start;
    logic                 r_irq_en;
    logic [1:0]           r_audio;
    logic                 r_pending;
    logic                 r_irq_flag;
    logic [7:0]           r_frame_cnt;
    logic [7:0]           r_readdata;

    logic [15:0]          r_sh_x [NUM_PILLARS];
    logic [7:0]           r_sh_h [NUM_PILLARS];
    logic [15:0]          r_sh_score;
    logic [15:0]          r_sh_bird;
    logic [7:0]           r_sh_move;

    logic [15:0]          r_ac_x [NUM_PILLARS];
    logic [7:0]           r_ac_h [NUM_PILLARS];
    logic [15:0]          r_ac_score;
    logic [15:0]          r_ac_bird;
    logic [7:0]           r_ac_move;

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_commit_req;
    logic                 w_xfer;
    logic [7:0]           w_rdata;

    assign w_wr         = chipselect && write;
    assign w_rd         = chipselect && read;
    assign w_commit_req = w_wr && (address == A_CTRL) && writedata[7];
    assign w_xfer       = frame_start && (r_pending || (AUTO_COMMIT != 0));

    // Control, status and frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start     <= 1'b0;
            r_irq_en    <= 1'b0;
            r_audio     <= 2'b00;
            r_pending   <= 1'b0;
            r_irq_flag  <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            if (w_wr && address == A_CTRL) begin
                r_start  <= writedata[0];
                r_irq_en <= writedata[1];
            end
            if (w_wr && address == A_AUDIO)
                r_audio <= writedata[1:0];
            // A COMMIT coinciding with a transfer re-arms for the next frame.
            if (w_commit_req)
                r_pending <= 1'b1;
            else if (w_xfer)
                r_pending <= 1'b0;
            // Interrupt set has priority over a same-cycle W1C.
            if (w_xfer && r_irq_en)
                r_irq_flag <= 1'b1;
            else if (w_wr && address == A_STAT && writedata[1])
                r_irq_flag <= 1'b0;
            if (frame_start)
                r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    // Shadow copies, written from the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PILLARS; i++) begin
                r_sh_x[i] <= f_x_rst(i);
                r_sh_h[i] <= f_h_rst(i);
            end
            r_sh_score <= SCORE_RST;
            r_sh_bird  <= BIRD_RST;
            r_sh_move  <= MOVE_RST;
        end else if (w_wr) begin
            if (address == A_SC_HI) r_sh_score[15:8] <= writedata;
            if (address == A_SC_LO) r_sh_score[7:0]  <= writedata;
            if (address == A_BD_HI) r_sh_bird[15:8]  <= writedata;
            if (address == A_BD_LO) r_sh_bird[7:0]   <= writedata;
            if (address == A_MOVE)  r_sh_move        <= writedata;
            for (int i = 0; i < NUM_PILLARS; i++) begin
                if (address == f_pa(i, 0)) r_sh_x[i][15:8] <= writedata;
                if (address == f_pa(i, 1)) r_sh_x[i][7:0]  <= writedata;
                if (address == f_pa(i, 2)) r_sh_h[i]       <= writedata;
            end
        end
    end

    // Active copies: take the pre-edge shadow, so a same-edge bus write stays in shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PILLARS; i++) begin
                r_ac_x[i] <= f_x_rst(i);
                r_ac_h[i] <= f_h_rst(i);
            end
            r_ac_score <= SCORE_RST;
            r_ac_bird  <= BIRD_RST;
            r_ac_move  <= MOVE_RST;
        end else if (w_xfer) begin
            for (int i = 0; i < NUM_PILLARS; i++) begin
                r_ac_x[i] <= r_sh_x[i];
                r_ac_h[i] <= r_sh_h[i];
            end
            r_ac_score <= r_sh_score;
            r_ac_bird  <= r_sh_bird;
            r_ac_move  <= r_sh_move;
        end
    end

    // Readback mux; shadowed fields return the shadow copy.
    always_comb begin
        w_rdata = 8'h00;
        case (address)
            A_CTRL:  w_rdata = {6'b0, r_irq_en, r_start};
            A_STAT:  w_rdata = {6'b0, r_irq_flag, r_pending};
            A_FCNT:  w_rdata = r_frame_cnt;
            A_AUDIO: w_rdata = {6'b0, r_audio};
            A_SC_HI: w_rdata = r_sh_score[15:8];
            A_SC_LO: w_rdata = r_sh_score[7:0];
            A_BD_HI: w_rdata = r_sh_bird[15:8];
            A_BD_LO: w_rdata = r_sh_bird[7:0];
            A_MOVE:  w_rdata = r_sh_move;
            default: w_rdata = 8'h00;
        endcase
        for (int i = 0; i < NUM_PILLARS; i++) begin
            if (address == f_pa(i, 0)) w_rdata = r_sh_x[i][15:8];
            if (address == f_pa(i, 1)) w_rdata = r_sh_x[i][7:0];
            if (address == f_pa(i, 2)) w_rdata = r_sh_h[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_readdata <= 8'h00;
        else if (w_rd)
            r_readdata <= w_rdata;
    end

    for (genvar g = 0; g < NUM_PILLARS; g++) begin : g_out
        assign pillar_x[16*g +: 16] = r_ac_x[g];
        assign pillar_h[8*g +: 8]   = r_ac_h[g];
    end

    assign readdata   = r_readdata;
    assign score      = r_ac_score;
    assign bird_y     = r_ac_bird;
    assign move       = r_ac_move;
    assign start      = r_start;
    assign audio_ctrl = r_audio;
    assign irq        = r_irq_flag & r_irq_en;

endmodule

// File: tb/tb_game_reg_bank.sv
// tb_game_reg_bank: directed and randomized checks of game_reg_bank
// against a register-map reference model.

module tb_game_reg_bank;

    localparam int NP = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          chipselect = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [5:0]    address = '0;
    logic [7:0]    writedata = '0;
    logic [7:0]    readdata;
    logic          frame_start = 1'b0;
    logic [47:0]   pillar_x;
    logic [23:0]   pillar_h;
    logic [15:0]   score;
    logic [15:0]   bird_y;
    logic [7:0]    move;
    logic          start;
    logic [1:0]    audio_ctrl;
    logic          irq;

    int vectors = 0;
    int miscompares = 0;

    game_reg_bank #(
        .NUM_PILLARS(NP),
        .ADDR_W(6),
        .AUTO_COMMIT(0),
        .PILLAR_SPACING(250)
    ) dut (
        .clk(clk),
        .reset(reset),
        .chipselect(chipselect),
        .write(write),
        .read(read),
        .address(address),
        .writedata(writedata),
        .readdata(readdata),
        .frame_start(frame_start),
        .pillar_x(pillar_x),
        .pillar_h(pillar_h),
        .score(score),
        .bird_y(bird_y),
        .move(move),
        .start(start),
        .audio_ctrl(audio_ctrl),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model state (plain integers per named field).
    int m_start, m_irqen, m_audio, m_pend, m_flag, m_fcnt, m_rdata;
    int sh_x[NP], sh_h[NP], ac_x[NP], ac_h[NP];
    int sh_score, sh_bird, sh_move, ac_score, ac_bird, ac_move;

    task automatic model_reset();
        m_start = 0; m_irqen = 0; m_audio = 0;
        m_pend = 0; m_flag = 0; m_fcnt = 0; m_rdata = 0;
        for (int i = 0; i < NP; i++) begin
            sh_x[i] = 50 + i * 250;
            sh_h[i] = 10 + 5 * i;
        end
        sh_score = 'h0888; sh_bird = 200; sh_move = 5;
        ac_x = sh_x; ac_h = sh_h;
        ac_score = sh_score; ac_bird = sh_bird; ac_move = sh_move;
    endtask

    function automatic int model_read(int a);
        int p, o;
        case (a)
            0: return m_start + 2 * m_irqen;
            1: return m_pend + 2 * m_flag;
            2: return m_fcnt;
            3: return m_audio;
            4: return sh_score / 256;
            5: return sh_score % 256;
            6: return sh_bird / 256;
            7: return sh_bird % 256;
            8: return sh_move;
            default: begin
                if (a < 16 || a >= 16 + 4 * NP) return 0;
                p = (a - 16) / 4;
                o = (a - 16) % 4;
                if (o == 0) return sh_x[p] / 256;
                if (o == 1) return sh_x[p] % 256;
                if (o == 2) return sh_h[p];
                return 0;
            end
        endcase
    endfunction

    function automatic int set_hi(int v, int b);
        return b * 256 + v % 256;
    endfunction

    function automatic int set_lo(int v, int b);
        return (v / 256) * 256 + b;
    endfunction

    task automatic model_step(bit cs, bit wr, bit rd, int a, int wd, bit fs);
        int rv, p, o;
        bit xfer, ien;
        int ox[NP], oh[NP];
        int os, ob, om;
        rv = model_read(a);
        xfer = fs && (m_pend == 1);
        ien = (m_irqen == 1);
        ox = sh_x; oh = sh_h;
        os = sh_score; ob = sh_bird; om = sh_move;
        if (xfer) m_pend = 0;
        if (cs && wr) begin
            case (a)
                0: begin
                    m_start = wd % 2;
                    m_irqen = (wd / 2) % 2;
                    if (wd >= 128) m_pend = 1;
                end
                1: if ((wd / 2) % 2 == 1) m_flag = 0;
                3: m_audio = wd % 4;
                4: sh_score = set_hi(sh_score, wd);
                5: sh_score = set_lo(sh_score, wd);
                6: sh_bird = set_hi(sh_bird, wd);
                7: sh_bird = set_lo(sh_bird, wd);
                8: sh_move = wd;
                default: begin
                    if (a >= 16 && a < 16 + 4 * NP) begin
                        p = (a - 16) / 4;
                        o = (a - 16) % 4;
                        if (o == 0) sh_x[p] = set_hi(sh_x[p], wd);
                        if (o == 1) sh_x[p] = set_lo(sh_x[p], wd);
                        if (o == 2) sh_h[p] = wd;
                    end
                end
            endcase
        end
        if (xfer && ien) m_flag = 1;
        if (xfer) begin
            ac_x = ox; ac_h = oh;
            ac_score = os; ac_bird = ob; ac_move = om;
        end
        if (fs) m_fcnt = (m_fcnt + 1) % 256;
        if (cs && rd) m_rdata = rv;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [47:0] ex;
        logic [23:0] eh;
        for (int i = 0; i < NP; i++) begin
            ex[16*i +: 16] = 16'(ac_x[i]);
            eh[8*i +: 8] = 8'(ac_h[i]);
        end
        chk("readdata", 64'(readdata), 64'(m_rdata));
        chk("pillar_x", 64'(pillar_x), 64'(ex));
        chk("pillar_h", 64'(pillar_h), 64'(eh));
        chk("score", 64'(score), 64'(ac_score));
        chk("bird_y", 64'(bird_y), 64'(ac_bird));
        chk("move", 64'(move), 64'(ac_move));
        chk("start", 64'(start), 64'(m_start));
        chk("audio_ctrl", 64'(audio_ctrl), 64'(m_audio));
        chk("irq", 64'(irq), 64'(m_flag & m_irqen));
    endtask

    task automatic step(bit rst, bit cs, bit wr, bit rd, int a, int wd, bit fs);
        reset = rst; chipselect = cs; write = wr; read = rd;
        address = 6'(a); writedata = 8'(wd); frame_start = fs;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(cs, wr, rd, a, wd, fs);
        #1;
        reset = 1'b0; chipselect = 1'b0; write = 1'b0;
        read = 1'b0; frame_start = 1'b0;
        check_all();
    endtask

    task automatic bus_wr(int a, int d);
        step(0, 1, 1, 0, a, d, 0);
    endtask

    task automatic bus_rd(int a);
        step(0, 1, 0, 1, a, 0, 0);
    endtask

    task automatic frame();
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int r, a, wd;
        bit cs, wr, rd, fs, rst;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_readdata", 64'(readdata), 64'h0);
        chk("rst_px0", 64'(pillar_x[15:0]), 64'd50);
        chk("rst_px1", 64'(pillar_x[31:16]), 64'd300);
        chk("rst_score", 64'(score), 64'h0888);
        bus_rd('h10);
        chk("rst_rd10", 64'(readdata), 64'h00);
        bus_rd('h11);
        chk("rst_rd11", 64'(readdata), 64'h32);

        // Shadow write without commit
        bus_wr('h10, 'h01);
        bus_wr('h11, 'h2C);
        repeat (3) frame();
        chk("nocommit_px0", 64'(pillar_x[15:0]), 64'd50);
        bus_rd('h11);
        chk("shadow_rd11", 64'(readdata), 64'h2C);
        bus_rd('h02);
        chk("fcnt3", 64'(readdata), 64'd3);

        // Commit with interrupt
        bus_wr('h00, 'h02);
        bus_wr('h00, 'h82);
        bus_rd('h01);
        chk("pending_set", 64'(readdata), 64'h01);
        frame();
        chk("commit_px0", 64'(pillar_x[15:0]), 64'd300);
        bus_rd('h01);
        chk("status_after", 64'(readdata), 64'h02);
        chk("irq_high", 64'(irq), 64'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("irq_hold", 64'(irq), 64'd1);
        bus_wr('h01, 'h02);
        chk("irq_w1c", 64'(irq), 64'd0);

        // COMMIT same cycle as frame_start, then write on transfer edge
        bus_wr('h08, 7);
        step(0, 1, 1, 0, 'h00, 'h82, 1);
        chk("samecyc_move", 64'(move), 64'd5);
        step(0, 1, 1, 0, 'h08, 9, 1);
        chk("xfer_move", 64'(move), 64'd7);
        bus_rd('h08);
        chk("move_shadow", 64'(readdata), 64'd9);

        // W1C on the irq set cycle: set wins
        bus_wr('h01, 'h02);
        bus_wr('h00, 'h82);
        step(0, 1, 1, 0, 'h01, 'h02, 1);
        chk("w1c_setwins", 64'(irq), 64'd1);

        // Reset discards a pending commit
        bus_wr('h00, 'h80);
        step(1, 0, 0, 0, 0, 0, 0);
        bus_rd('h01);
        chk("rst_pending", 64'(readdata), 64'h00);
        bus_wr('h11, 'h99);
        frame();
        chk("rst_noxfer", 64'(pillar_x[15:0]), 64'd50);
        bus_rd('h3F);
        chk("unmapped", 64'(readdata), 64'h00);

        // Frame counter wrap
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (256) frame();
        bus_rd('h02);
        chk("fcnt_wrap", 64'(readdata), 64'h00);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 199);
            rst = (r == 0);
            cs = ($urandom_range(0, 9) != 0);
            wr = $urandom_range(0, 1) == 1;
            rd = $urandom_range(0, 1) == 1;
            fs = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 9);
            if (r < 3) a = $urandom_range(0, 8);
            else if (r < 8) a = $urandom_range(16, 16 + 4 * NP - 1);
            else a = $urandom_range(0, 63);
            wd = $urandom_range(0, 255);
            step(rst, cs, wr, rd, a, wd, fs);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
